// File: rtl/rgb_pwm_pkg.sv
// Shared types and helpers for the RGB PWM colour sequencer.
// Holds the controller state encoding, channel indices and the colour-code decode.
package rgb_pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_e;

    localparam int CH_RED   = 0;
    localparam int CH_GREEN = 1;
    localparam int CH_BLUE  = 2;

    // Unlit channels go dark; lit channels go to full or half brightness depending on the bright bit.
    function automatic logic [31:0] decode_target(input logic chanOn, input logic bright, input int pwmW);
        logic [31:0] result;
        if (!chanOn) begin
            result = 32'd0;
        end else if (bright) begin
            result = (32'd1 << pwmW) - 32'd1;
        end else begin
            result = 32'd1 << (pwmW - 1);
        end
        return result;
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: latched target, current duty that fades toward it,
// and the registered compare that drives the output pin.
module rgb_pwm_channel #(
    parameter int PWM_W = 8,
    parameter int STEP  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [PWM_W-1:0] target_i,
    input  logic             step_i,
    input  logic [PWM_W-1:0] cnt_i,
    input  logic             enable_i,
    output logic             pwm_o,
    output logic             done_o
);

    localparam logic [PWM_W-1:0] STEP_V = PWM_W'(STEP);

    logic [PWM_W-1:0] target_q, target_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic [PWM_W-1:0] stepped;

    // Step toward the target, landing exactly on it when less than one step away.
    always_comb begin
        target_d = target_q;
        duty_d   = duty_q;
        stepped  = duty_q;
        if (duty_q < target_q) begin
            stepped = ((target_q - duty_q) > STEP_V) ? (duty_q + STEP_V) : target_q;
        end else if (duty_q > target_q) begin
            stepped = ((duty_q - target_q) > STEP_V) ? (duty_q - STEP_V) : target_q;
        end
        if (load_i) begin
            target_d = target_i;
        end
        if (step_i) begin
            duty_d = stepped;
        end
        pwm_d = enable_i && (cnt_i < duty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o  = pwm_q;
    assign done_o = (stepped == target_q);

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// RGB PWM colour sequencer: accepts a colour code, then fades every channel
// toward its decoded brightness one step per PWM period.
module rgb_pwm_sequencer
    import rgb_pwm_pkg::*;
#(
    parameter int CODE_W = 4,
    parameter int NCH    = 3,
    parameter int PWM_W  = 8,
    parameter int STEP   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              enable,
    output logic [NCH-1:0]    pwm_out,
    output logic              busy
);

    state_e           state_q, state_d;
    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic             wrapCycle;
    logic             acceptCode;
    logic             stepEn;
    logic             allDone;
    logic [NCH-1:0]   doneVec;
    logic [PWM_W-1:0] targetVec [NCH];

    assign wrapCycle  = (cnt_q == {PWM_W{1'b1}});
    assign acceptCode = code_valid && (state_q == IDLE);
    assign stepEn     = (state_q == FADE) && wrapCycle;
    assign allDone    = &doneVec;

    // Fades finish on the period boundary where every channel has just reached its target.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            IDLE: if (acceptCode) state_d = FADE;
            FADE: if (wrapCycle && allDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign code_ready = (state_q == IDLE);
    assign busy       = (state_q == FADE);

    for (genvar c = 0; c < NCH; c++) begin : gen_ch
        assign targetVec[c] = PWM_W'(decode_target(code[c], code[CODE_W-1], PWM_W));

        rgb_pwm_channel #(
            .PWM_W (PWM_W),
            .STEP  (STEP)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_i   (acceptCode),
            .target_i (targetVec[c]),
            .step_i   (stepEn),
            .cnt_i    (cnt_q),
            .enable_i (enable),
            .pwm_o    (pwm_out[c]),
            .done_o   (doneVec[c])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Scoreboard bench for rgb_pwm_sequencer: each accepted code queues the expected
// per-period duties and busy state, and a monitor measures every PWM period.
module tb_rgb_pwm_sequencer;

    localparam int CODE_W = 4;
    localparam int NCH    = 3;
    localparam int PWM_W  = 8;
    localparam int STEP   = 16;
    localparam int PERIOD = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  code;
    logic        code_valid;
    logic        code_ready;
    logic        enable;
    logic [2:0]  pwm_out;
    logic        busy;

    typedef struct {
        int duty [3];
        bit busyExp;
    } period_t;

    period_t    sbQ [$];
    int         modelDuty [3];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] tbCnt;
    logic       enAtEdge;

    int   hiCnt [3];
    int   nSamp;
    bit   enLowSeen;
    logic busyMid;

    always #5 clk = ~clk;

    rgb_pwm_sequencer #(
        .CODE_W (CODE_W),
        .NCH    (NCH),
        .PWM_W  (PWM_W),
        .STEP   (STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .enable     (enable),
        .pwm_out    (pwm_out),
        .busy       (busy)
    );

    // Reference counter: free-running from zero after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbCnt <= 8'd0;
        else        tbCnt <= tbCnt + 8'd1;
    end

    // Enable as the DUT saw it on the edge that produced the current pwm_out.
    always @(posedge clk) enAtEdge <= enable;

    // Period monitor: pwm_out seen at a negedge reflects counter value tbCnt-1.
    always @(negedge clk) begin
        logic [7:0] phase;
        period_t    e;
        if (!rst_n) begin
            nSamp     = 0;
            enLowSeen = 0;
            for (int c = 0; c < 3; c++) hiCnt[c] = 0;
        end else begin
            phase = tbCnt - 8'd1;
            if (phase == 8'd0) begin
                nSamp     = 0;
                enLowSeen = 0;
                for (int c = 0; c < 3; c++) hiCnt[c] = 0;
            end
            for (int c = 0; c < 3; c++) if (pwm_out[c] === 1'b1) hiCnt[c]++;
            nSamp++;
            if (enAtEdge !== 1'b1) begin
                enLowSeen = 1;
                checks++;
                if (pwm_out !== 3'b000) begin
                    failures++;
                    $display("[TB] FAIL gated_output t=%0t got=%b want=000", $time, pwm_out);
                end
            end
            if (tbCnt == 8'd128) busyMid = busy;
            if (phase == 8'd255 && nSamp == PERIOD && sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checks++;
                if (busyMid !== e.busyExp) begin
                    failures++;
                    $display("[TB] FAIL period_busy t=%0t got=%b want=%b", $time, busyMid, e.busyExp);
                end
                if (!enLowSeen) begin
                    for (int c = 0; c < 3; c++) begin
                        checks++;
                        if (hiCnt[c] != e.duty[c]) begin
                            failures++;
                            $display("[TB] FAIL period_duty ch%0d t=%0t got=%0d want=%0d",
                                     c, $time, hiCnt[c], e.duty[c]);
                        end
                    end
                end
            end
        end
    end

    // Queue the whole expected trajectory for a code accepted mid-period.
    task automatic pushFade(input logic [3:0] c);
        int      tgt [3];
        period_t e;
        bit      done;
        for (int ch = 0; ch < 3; ch++) begin
            if (c[ch] == 1'b0)      tgt[ch] = 0;
            else if (c[3] == 1'b1)  tgt[ch] = 255;
            else                    tgt[ch] = 128;
        end
        e.duty    = modelDuty;
        e.busyExp = 1'b1;
        sbQ.push_back(e);
        do begin
            done = 1'b1;
            for (int ch = 0; ch < 3; ch++) begin
                if (modelDuty[ch] < tgt[ch])
                    modelDuty[ch] = (tgt[ch] - modelDuty[ch] > STEP) ? modelDuty[ch] + STEP : tgt[ch];
                else if (modelDuty[ch] > tgt[ch])
                    modelDuty[ch] = (modelDuty[ch] - tgt[ch] > STEP) ? modelDuty[ch] - STEP : tgt[ch];
                if (modelDuty[ch] != tgt[ch]) done = 1'b0;
            end
            e.duty    = modelDuty;
            e.busyExp = !done;
            sbQ.push_back(e);
        end while (!done);
        e.busyExp = 1'b0;
        sbQ.push_back(e);
        sbQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] c);
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            if (tbCnt == 8'd10) break;
        end
        code       = c;
        code_valid = 1'b1;
        pushFade(c);
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic waitEmpty(input int maxCycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (sbQ.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        enable     = 1'b1;
        code       = 4'b1001;
        code_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pwm_out !== 3'b000 || busy !== 1'b0 || code_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_state got pwm=%b busy=%b ready=%b want pwm=000 busy=0 ready=1",
                     pwm_out, busy, code_ready);
        end
        code_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pwm_out !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_no_accept got busy=%b pwm=%b want busy=0 pwm=000", busy, pwm_out);
        end
    endtask

    task automatic test_fade_up();
        bit ok;
        applyStimulus(4'b1001);
        waitEmpty(25 * PERIOD, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL fade_up_timeout pending=%0d want=0", sbQ.size());
        end
    endtask

    task automatic test_fade_cross();
        bit ok;
        applyStimulus(4'b0010);
        waitEmpty(25 * PERIOD, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL fade_cross_timeout pending=%0d want=0", sbQ.size());
        end
    endtask

    task automatic test_ignore_during_fade();
        bit ok;
        applyStimulus(4'b1100);
        repeat (300) @(negedge clk);
        code       = 4'b0001;
        code_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (code_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ignore_ready got ready=%b busy=%b want ready=0 busy=1", code_ready, busy);
            end
        end
        code_valid = 1'b0;
        waitEmpty(25 * PERIOD, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL ignore_timeout pending=%0d want=0", sbQ.size());
        end
    endtask

    task automatic test_enable_gate();
        bit ok;
        applyStimulus(4'b0011);
        repeat (600) @(negedge clk);
        enable = 1'b0;
        repeat (300) @(negedge clk);
        enable = 1'b1;
        waitEmpty(25 * PERIOD, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL enable_timeout pending=%0d want=0", sbQ.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        applyStimulus(4'b0011);
        waitEmpty(8 * PERIOD, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL equal_code_timeout pending=%0d want=0", sbQ.size());
        end
    endtask

    task automatic test_reset_mid_fade();
        bit ok;
        applyStimulus(4'b1111);
        repeat (700) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 3'b000 || busy !== 1'b0 || code_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midfade_reset got pwm=%b busy=%b ready=%b want pwm=000 busy=0 ready=1",
                     pwm_out, busy, code_ready);
        end
        sbQ.delete();
        for (int c = 0; c < 3; c++) modelDuty[c] = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        code       = 4'b0100;
        code_valid = 1'b1;
        checks++;
        if (code_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_ready got=%b want=1", code_ready);
        end
        pushFade(4'b0100);
        @(posedge clk);
        @(negedge clk);
        code_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_accept got busy=%b want=1", busy);
        end
        waitEmpty(25 * PERIOD, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL post_reset_timeout pending=%0d want=0", sbQ.size());
        end
    endtask

    task automatic checkOutput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        for (int c = 0; c < 3; c++) modelDuty[c] = 0;
        test_reset();
        test_fade_up();
        test_fade_cross();
        test_ignore_during_fade();
        test_enable_gate();
        test_back_to_back();
        test_reset_mid_fade();
        checkOutput();
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog t=%0t pending=%0d want=finished", $time, sbQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
